// File: rtl/part_2_rcv_sync.sv
// Receive-side synchronizer for the partition-2 initiator: tracks per-event
// fetch requests, holds mission clocks, and captures mailbox payloads under a watchdog.
module part_2_rcv_sync #(
  parameter int N_EV     = 4,
  parameter int DW       = 9,
  parameter int WDOG_MAX = 100,
  parameter int SEL_EV   = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_EV-1:0]         req_i,
  input  logic                    lut_valid_i,
  input  logic [$clog2(N_EV):0]   lut_event_i,
  input  logic [DW-1:0]           lut_data_i,
  output logic                    lut_ack_o,
  output logic [N_EV-1:0]         freeze_clk,
  output logic [N_EV-1:0]         rcv_valid_o,
  output logic [N_EV*DW-1:0]      rcv_data_o,
  output logic                    valid,
  output logic [DW-2:0]           o_data,
  output logic                    timeout_o,
  output logic                    unexp_o,
  output logic                    overrun_o,
  output logic                    busy_o
);

  localparam int EVW = $clog2(N_EV) + 1;
  localparam int IW  = (N_EV > 1) ? $clog2(N_EV) : 1;
  localparam int WW  = $clog2(WDOG_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR
  } state_t;

  state_t            state;
  logic [N_EV-1:0]   pending;
  logic [WW-1:0]     wdog;

  logic              in_range;
  logic [IW-1:0]     ev_idx;
  logic              live;
  logic              match;
  logic              drop;
  logic [N_EV-1:0]   match_vec;
  logic [N_EV-1:0]   pending_nxt;
  logic              ovr;

  always_comb begin
    in_range    = (lut_event_i < EVW'(N_EV));
    ev_idx      = lut_event_i[IW-1:0];
    live        = !rst_i && (state != S_ERR);
    match       = live && lut_valid_i && in_range && pending[ev_idx];
    drop        = live && lut_valid_i && !match;
    lut_ack_o   = match || drop;
    match_vec   = match ? (N_EV'(1) << ev_idx) : '0;
    // A request landing on the event being captured re-arms it instead of overrunning.
    pending_nxt = (pending & ~match_vec) | req_i;
    ovr         = |(req_i & pending & ~match_vec);
    busy_o      = (state == S_WAIT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      pending     <= '0;
      wdog        <= '0;
      freeze_clk  <= '0;
      rcv_valid_o <= '0;
      rcv_data_o  <= '0;
      valid       <= 1'b0;
      o_data      <= '0;
      timeout_o   <= 1'b0;
      unexp_o     <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      pending     <= pending_nxt;
      rcv_valid_o <= match_vec;
      for (int unsigned k = 0; k < N_EV; k++) begin
        if (match_vec[k]) rcv_data_o[k*DW +: DW] <= lut_data_i;
      end
      if (match_vec[SEL_EV]) {valid, o_data} <= lut_data_i;
      if (drop) unexp_o <= 1'b1;
      if (ovr) overrun_o <= 1'b1;

      case (state)
        S_IDLE: begin
          wdog       <= '0;
          freeze_clk <= pending_nxt;
          if (|pending_nxt) state <= S_WAIT;
        end
        S_WAIT: begin
          freeze_clk <= pending_nxt;
          if (match) begin
            wdog <= '0;
            if (pending_nxt == '0) state <= S_IDLE;
          end else if (wdog == WW'(WDOG_MAX)) begin
            state     <= S_ERR;
            timeout_o <= 1'b1;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        S_ERR: begin
          timeout_o <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_part_2_rcv_sync.sv
// Directed table-driven bench for part_2_rcv_sync plus watchdog boundary sequences.
module tb_part_2_rcv_sync;

  logic        clk_i;
  logic        rst_i;
  logic [3:0]  req_i;
  logic        lut_valid_i;
  logic [2:0]  lut_event_i;
  logic [8:0]  lut_data_i;
  logic        lut_ack_o;
  logic [3:0]  freeze_clk;
  logic [3:0]  rcv_valid_o;
  logic [35:0] rcv_data_o;
  logic        valid;
  logic [7:0]  o_data;
  logic        timeout_o;
  logic        unexp_o;
  logic        overrun_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  part_2_rcv_sync #(
    .N_EV(4),
    .DW(9),
    .WDOG_MAX(100),
    .SEL_EV(3)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(req_i),
    .lut_valid_i(lut_valid_i),
    .lut_event_i(lut_event_i),
    .lut_data_i(lut_data_i),
    .lut_ack_o(lut_ack_o),
    .freeze_clk(freeze_clk),
    .rcv_valid_o(rcv_valid_o),
    .rcv_data_o(rcv_data_o),
    .valid(valid),
    .o_data(o_data),
    .timeout_o(timeout_o),
    .unexp_o(unexp_o),
    .overrun_o(overrun_o),
    .busy_o(busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        lv;
    logic [2:0]  ev;
    logic [8:0]  data;
    logic        ack;
    logic [3:0]  frz;
    logic [3:0]  rv;
    logic        vld;
    logic [7:0]  od;
    logic        busy;
    logic        unx;
    logic        ovr;
    logic [35:0] rd;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mkv(input logic rst, input logic [3:0] req, input logic lv,
                               input logic [2:0] ev, input logic [8:0] data, input logic ack,
                               input logic [3:0] frz, input logic [3:0] rv, input logic vld,
                               input logic [7:0] od, input logic busy, input logic unx,
                               input logic ovr, input logic [35:0] rd);
    vec_t v;
    v.rst = rst; v.req = req; v.lv = lv; v.ev = ev; v.data = data;
    v.ack = ack; v.frz = frz; v.rv = rv; v.vld = vld; v.od = od;
    v.busy = busy; v.unx = unx; v.ovr = ovr; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] req, input logic lv,
                       input logic [2:0] ev, input logic [8:0] data);
    rst_i       = rst;
    req_i       = req;
    lut_valid_i = lv;
    lut_event_i = ev;
    lut_data_i  = data;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [35:0] rd_a;
    logic [35:0] rd_b;
    logic [35:0] rd_c;
    rd_a = {9'h1A5, 9'h000, 9'h000, 9'h000};
    rd_b = {9'h1A5, 9'h033, 9'h000, 9'h000};
    rd_c = {9'h1A5, 9'h033, 9'h000, 9'h144};

    //            rst  req    lv ev  data    ack frz    rv     vld od     bsy unx ovr rd
    tbl[0]  = mkv(1, 4'b0001, 1, 3, 9'h1A5, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0, '0);
    tbl[1]  = mkv(0, 4'b1000, 0, 0, 9'h000, 0, 4'b1000, 4'b0000, 0, 8'h00, 1, 0, 0, '0);
    tbl[2]  = mkv(0, 4'b0000, 0, 0, 9'h000, 0, 4'b1000, 4'b0000, 0, 8'h00, 1, 0, 0, '0);
    tbl[3]  = mkv(0, 4'b0000, 0, 0, 9'h000, 0, 4'b1000, 4'b0000, 0, 8'h00, 1, 0, 0, '0);
    tbl[4]  = mkv(0, 4'b0000, 1, 3, 9'h1A5, 1, 4'b0000, 4'b1000, 1, 8'hA5, 0, 0, 0, rd_a);
    tbl[5]  = mkv(0, 4'b0000, 0, 0, 9'h000, 0, 4'b0000, 4'b0000, 1, 8'hA5, 0, 0, 0, rd_a);
    tbl[6]  = mkv(0, 4'b0101, 0, 0, 9'h000, 0, 4'b0101, 4'b0000, 1, 8'hA5, 1, 0, 0, rd_a);
    tbl[7]  = mkv(0, 4'b0000, 1, 2, 9'h033, 1, 4'b0001, 4'b0100, 1, 8'hA5, 1, 0, 0, rd_b);
    tbl[8]  = mkv(0, 4'b0000, 1, 0, 9'h144, 1, 4'b0000, 4'b0001, 1, 8'hA5, 0, 0, 0, rd_c);
    tbl[9]  = mkv(0, 4'b0000, 1, 2, 9'h0FF, 1, 4'b0000, 4'b0000, 1, 8'hA5, 0, 1, 0, rd_c);
    tbl[10] = mkv(0, 4'b0000, 1, 4, 9'h0EE, 1, 4'b0000, 4'b0000, 1, 8'hA5, 0, 1, 0, rd_c);
    tbl[11] = mkv(0, 4'b1010, 0, 0, 9'h000, 0, 4'b1010, 4'b0000, 1, 8'hA5, 1, 1, 0, rd_c);
    tbl[12] = mkv(1, 4'b0000, 1, 1, 9'h0AB, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0, '0);
    tbl[13] = mkv(0, 4'b1000, 0, 0, 9'h000, 0, 4'b1000, 4'b0000, 0, 8'h00, 1, 0, 0, '0);
    tbl[14] = mkv(0, 4'b1000, 1, 3, 9'h0C3, 1, 4'b1000, 4'b1000, 0, 8'hC3, 1, 0, 0,
                  {9'h0C3, 27'h0});
    tbl[15] = mkv(0, 4'b1000, 0, 0, 9'h000, 0, 4'b1000, 4'b0000, 0, 8'hC3, 1, 0, 1,
                  {9'h0C3, 27'h0});
    tbl[16] = mkv(0, 4'b0000, 1, 3, 9'h1FF, 1, 4'b0000, 4'b1000, 1, 8'hFF, 0, 0, 1,
                  {9'h1FF, 27'h0});
    tbl[17] = mkv(1, 4'b0000, 0, 0, 9'h000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0, '0);

    drive(1, '0, 0, '0, '0);
    tick();

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].lv, tbl[i].ev, tbl[i].data);
      #1;
      chk($sformatf("r%0d ack", i), 64'(lut_ack_o), 64'(tbl[i].ack));
      tick();
      chk($sformatf("r%0d freeze", i),  64'(freeze_clk),  64'(tbl[i].frz));
      chk($sformatf("r%0d rcv_valid", i), 64'(rcv_valid_o), 64'(tbl[i].rv));
      chk($sformatf("r%0d valid", i),   64'(valid),       64'(tbl[i].vld));
      chk($sformatf("r%0d o_data", i),  64'(o_data),      64'(tbl[i].od));
      chk($sformatf("r%0d busy", i),    64'(busy_o),      64'(tbl[i].busy));
      chk($sformatf("r%0d unexp", i),   64'(unexp_o),     64'(tbl[i].unx));
      chk($sformatf("r%0d overrun", i), 64'(overrun_o),   64'(tbl[i].ovr));
      chk($sformatf("r%0d rcv_data", i), 64'(rcv_data_o), 64'(tbl[i].rd));
      chk($sformatf("r%0d timeout", i), 64'(timeout_o),   64'h0);
    end

    // Payload arrives in the last tolerated WAIT cycle: captured, no timeout.
    drive(0, 4'b0010, 0, '0, '0);
    tick();
    drive(0, '0, 0, '0, '0);
    for (int c = 0; c < 100; c++) tick();
    chk("edge timeout_before", 64'(timeout_o), 64'h0);
    chk("edge busy_before", 64'(busy_o), 64'h1);
    drive(0, '0, 1, 3'd1, 9'h155);
    #1;
    chk("edge ack", 64'(lut_ack_o), 64'h1);
    tick();
    drive(0, '0, 0, '0, '0);
    chk("edge timeout_after", 64'(timeout_o), 64'h0);
    chk("edge rcv_valid", 64'(rcv_valid_o), 64'h2);
    chk("edge freeze", 64'(freeze_clk), 64'h0);
    chk("edge busy_after", 64'(busy_o), 64'h0);
    chk("edge rcv_data", 64'(rcv_data_o), 64'({9'h0, 9'h0, 9'h155, 9'h0}));

    // No payload for 101 WAIT cycles: watchdog error, then everything locked.
    drive(0, 4'b0010, 0, '0, '0);
    tick();
    drive(0, '0, 0, '0, '0);
    for (int c = 0; c < 100; c++) tick();
    chk("wd timeout_at_100", 64'(timeout_o), 64'h0);
    tick();
    chk("wd timeout_set", 64'(timeout_o), 64'h1);
    chk("wd busy", 64'(busy_o), 64'h0);
    chk("wd freeze", 64'(freeze_clk), 64'h2);
    drive(0, '0, 1, 3'd1, 9'h0AA);
    #1;
    chk("wd late_ack", 64'(lut_ack_o), 64'h0);
    tick();
    chk("wd late_rcv_valid", 64'(rcv_valid_o), 64'h0);
    chk("wd late_rcv_data", 64'(rcv_data_o), 64'({9'h0, 9'h0, 9'h155, 9'h0}));
    chk("wd late_unexp", 64'(unexp_o), 64'h0);
    drive(0, 4'b0100, 0, '0, '0);
    tick();
    drive(0, '0, 0, '0, '0);
    tick();
    chk("wd freeze_hold", 64'(freeze_clk), 64'h2);
    chk("wd timeout_sticky", 64'(timeout_o), 64'h1);

    drive(1, '0, 0, '0, '0);
    tick();
    chk("rst timeout_clr", 64'(timeout_o), 64'h0);
    chk("rst freeze_clr", 64'(freeze_clk), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
